regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It serves the non-forwarding pipeline: it supplies NUM_RD combinational operand reads and accepts NUM_WR writeback writes. It also tracks which destination registers have an in-flight writer, and raises `hazard_o` so the decode stage stalls. Register 0 is hardwired to zero throughout.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- rd_addr_i  in  NUM_RD x ADDR_W  read addresses
- rd_data_o  out  NUM_RD x DATA_W  read data, combinational
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR x ADDR_W  write addresses
- wr_data_i  in  NUM_WR x DATA_W  write data
- iss_vld_i  in  1  decode presents an instruction this cycle
- iss_rs1_i, iss_rs2_i  in  ADDR_W each  source registers of the issuing instruction
- iss_rs1_use_i, iss_rs2_use_i  in  1 each  source is actually read
- iss_rd_i  in  ADDR_W  destination of the issuing instruction
- iss_rd_wen_i  in  1  instruction writes iss_rd_i
- hazard_o  out  1  issuing instruction must stall; combinational
- busy_o  out  NUM_REGS  scoreboard busy vector; registered, bit 0 always 0

## Operation
- Reset:
  - All registers clear to 0.
  - All busy bits clear to 0.
  - `hazard_o` is 0 while `iss_vld_i` is 0.
- Register 0:
  - Reads return 0.
  - Writes to it are dropped.
  - It is never marked busy and never causes a hazard.
- Read: `rd_data_o[k]` is `regs[rd_addr_i[k]]`, subject to the bypass rule under Configuration.
- Write: on a clock edge, each port with `wr_en_i` high and a nonzero address updates that register.
  - When two ports target the same address, the higher port index wins.
- Hazard: `hazard_o` = `iss_vld_i` AND at least one of the following:
  - `iss_rs1_use_i` is high and rs1 is busy.
  - `iss_rs2_use_i` is high and rs2 is busy.
  - `iss_rd_wen_i` is high and rd is busy (WAW).
- Reserve: on a clock edge where `iss_vld_i`, `iss_rd_wen_i` and `!hazard_o` all hold, and rd is nonzero, set `busy[rd]`.
- Release: on a clock edge, for each `wr_en_i` port with a nonzero address, clear `busy[wr_addr]`.
- Simultaneous reserve and release of the same register: reserve wins, so the bit stays 1.
- Release of a register that is not busy is legal and has no effect.
- A write to a register with no reservation still updates it.

## Timing
- Read latency is 0 cycles (combinational).
- A write is visible to reads on the cycle after its edge.
- With the bypass option, a write is also visible in the same cycle.
- `busy_o` reflects reservations and releases from the previous edge.
- Asserting `rst_ni` low at any time, including mid-operation, immediately clears all registers and busy bits. It does not wait for a clock.
- Deassertion is taken synchronously: the first edge with `rst_ni` high performs normal updates.

## Configuration
Macro `REGFILE_SB_BYPASS_EN`:
- Defined:
  - Each read port compares its address against every enabled write port; on a match with a nonzero address it returns `wr_data_i`. When several ports match, the highest index wins.
  - The hazard check treats a register as not busy when a same-cycle write releases it, so an instruction stalled on writeback issues in the writeback cycle.
- Undefined:
  - Reads return stored values only.
  - Hazard uses the registered busy bits, so the stall lasts one cycle longer: the instruction issues on the cycle after writeback.

## Structure
- Shared package `regfile_pkg`:
  - parameter defaults: DATA_W, ADDR_W, NUM_RD, NUM_WR
  - typedefs `reg_addr_t` and `reg_data_t`
  - constant `REG_ZERO` = 0
- One sub-module, `regfile_scoreboard`:
  - contains the busy vector, hazard logic and reserve/release/priority logic
  - takes the write enables and addresses as release inputs
  - the top level holds the storage and read muxes

## Test plan
- Reset mid-run: write x5=0xDEADBEEF, reserve x7, then pull `rst_ni` low between edges -> x5 reads 0 and `busy_o` = 0 immediately.
- x0 handling: write x0=0x12345678 -> reads return 0; issue with rd=x0 -> `busy_o[0]` stays 0.
- RAW stall: issue rd=x3 wen, then next instruction reads rs1=x3 -> `hazard_o`=1 until writeback of x3=0xA5A5A5A5.
  - Bypass defined: issues in the writeback cycle and reads 0xA5A5A5A5 that cycle.
  - Bypass undefined: issues one cycle later.
- Same-cycle reserve and release of x9 -> `busy_o[9]`=1 after the edge; one further release -> 0.
- NUM_WR=2, both ports write x4 (port0 0x1, port1 0x2) -> x4 reads 0x2; both busy releases apply.
- NUM_RD=4: four different addresses are read in one cycle after writes 0x10, 0x20, 0x30, 0x40 -> each port returns its own value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / scoreboard slice.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned NUM_WR_DEF = 1;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Architectural zero register index.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight writers, raises hazard for decode.
// REGFILE_SB_BYPASS_EN: same-cycle releases hide busy bits from the hazard check.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_WR = NUM_WR_DEF,
  localparam int unsigned NUM_REGS = 1 << ADDR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_WR-1:0]             rel_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] rel_addr_i,
  input  logic                          iss_vld_i,
  input  logic [ADDR_W-1:0]             iss_rs1_i,
  input  logic [ADDR_W-1:0]             iss_rs2_i,
  input  logic                          iss_rs1_use_i,
  input  logic                          iss_rs2_use_i,
  input  logic [ADDR_W-1:0]             iss_rd_i,
  input  logic                          iss_rd_wen_i,
  output logic                          hazard_o,
  output logic [NUM_REGS-1:0]           busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] rel_vec;
  logic [NUM_REGS-1:0] eff_busy;

  // Decode release ports into a one-hot-per-port clear vector.
  always_comb begin
    rel_vec = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (rel_en_i[w] && rel_addr_i[w] != ZERO_ADDR) begin
        rel_vec[rel_addr_i[w]] = 1'b1;
      end
    end
  end

  // Busy view seen by the hazard check.
  always_comb begin
`ifdef REGFILE_SB_BYPASS_EN
    eff_busy = busy_q & ~rel_vec;
`else
    eff_busy = busy_q;
`endif
  end

  // Stall on RAW for used sources and on WAW for a written destination.
  always_comb begin
    hazard_o = iss_vld_i &
               ((iss_rs1_use_i & eff_busy[iss_rs1_i]) |
                (iss_rs2_use_i & eff_busy[iss_rs2_i]) |
                (iss_rd_wen_i  & eff_busy[iss_rd_i]));
  end

  // Release first, then reserve, so a simultaneous reserve keeps the bit set.
  always_comb begin
    busy_d = busy_q & ~rel_vec;
    if (iss_vld_i && iss_rd_wen_i && !hazard_o && iss_rd_i != ZERO_ADDR) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy vector register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with integrated busy-bit scoreboard.
// REGFILE_SB_BYPASS_EN: reads forward same-cycle write data.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF,
  parameter int unsigned NUM_WR = NUM_WR_DEF,
  localparam int unsigned NUM_REGS = 1 << ADDR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data_o,
  input  logic [NUM_WR-1:0]             wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
  input  logic                          iss_vld_i,
  input  logic [ADDR_W-1:0]             iss_rs1_i,
  input  logic [ADDR_W-1:0]             iss_rs2_i,
  input  logic                          iss_rs1_use_i,
  input  logic                          iss_rs2_use_i,
  input  logic [ADDR_W-1:0]             iss_rd_i,
  input  logic                          iss_rd_wen_i,
  output logic                          hazard_o,
  output logic [NUM_REGS-1:0]           busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Apply write ports in ascending order so the highest index wins; x0 never written.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && wr_addr_i[w] != ZERO_ADDR) begin
        regs_d[wr_addr_i[w]] = wr_data_i[w];
      end
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports; x0 reads zero because it is never written.
  always_comb begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_data_o[k] = regs_q[rd_addr_i[k]];
`ifdef REGFILE_SB_BYPASS_EN
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] == rd_addr_i[k] && rd_addr_i[k] != ZERO_ADDR) begin
          rd_data_o[k] = wr_data_i[w];
        end
      end
`endif
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rel_en_i      (wr_en_i),
    .rel_addr_i    (wr_addr_i),
    .iss_vld_i     (iss_vld_i),
    .iss_rs1_i     (iss_rs1_i),
    .iss_rs2_i     (iss_rs2_i),
    .iss_rs1_use_i (iss_rs1_use_i),
    .iss_rs2_use_i (iss_rs2_use_i),
    .iss_rd_i      (iss_rd_i),
    .iss_rd_wen_i  (iss_rd_wen_i),
    .hazard_o      (hazard_o),
    .busy_o        (busy_o)
  );

endmodule
